// File: rtl/core_bus_slave_if.sv
// Host bus bundle for core_bus_slave: single-word reads/writes with one-cycle read return.
interface core_bus_slave_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writeData;
  logic        read;
  logic [31:0] readData;
  logic        readDataValid;

  modport master (
    output address,
    output write,
    output writeData,
    output read,
    input  readData,
    input  readDataValid
  );

  modport slave (
    input  address,
    input  write,
    input  writeData,
    input  read,
    output readData,
    output readDataValid
  );
endinterface

// File: rtl/core_bus_slave.sv
// Register front end for the counter core: decodes host bus accesses into per-register
// strobes, returns read data one cycle later and latches the core's interrupt for the host.
module core_bus_slave #(
  parameter logic [31:0] ID_VALUE = 32'h0001_0001
) (
  input  logic                    clk,
  input  logic                    reset,
  core_bus_slave_if.slave         bus,
  output logic                    irqOut,
  output logic [31:0]             counter1In,
  output logic [31:0]             counter2In,
  output logic                    counter1We,
  output logic                    counter2We,
  output logic                    counter1Re,
  output logic                    counter2Re,
  input  logic [31:0]             counter1,
  input  logic [31:0]             counter2,
  input  logic                    irq
);

  localparam logic [2:0] AddrCounter1  = 3'd0;
  localparam logic [2:0] AddrCounter2  = 3'd1;
  localparam logic [2:0] AddrIrqStatus = 3'd2;
  localparam logic [2:0] AddrIrqEnable = 3'd3;
  localparam logic [2:0] AddrId        = 3'd4;

  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic [31:0] counter1_in_q, counter1_in_d;
  logic [31:0] counter2_in_q, counter2_in_d;
  logic        counter1_we_q, counter1_we_d;
  logic        counter2_we_q, counter2_we_d;
  logic        counter1_re_q, counter1_re_d;
  logic        counter2_re_q, counter2_re_d;
  logic        pending_q, pending_d;
  logic        enable_q, enable_d;
  logic        irq_prev_q;

  logic wr_en;
  logic rd_en;
  logic irq_rise;
  logic w1c;

  // Decode the current access and compute next-state for all registers.
  always_comb begin
    wr_en = bus.write;
    // A simultaneous write wins; the read is dropped entirely.
    rd_en = bus.read & ~bus.write;

    counter1_in_d = counter1_in_q;
    counter2_in_d = counter2_in_q;
    counter1_we_d = 1'b0;
    counter2_we_d = 1'b0;
    counter1_re_d = 1'b0;
    counter2_re_d = 1'b0;
    enable_d      = enable_q;
    read_valid_d  = rd_en;
    read_data_d   = '0;

    if (wr_en) begin
      case (bus.address)
        AddrCounter1: begin
          counter1_in_d = bus.writeData;
          counter1_we_d = 1'b1;
        end
        AddrCounter2: begin
          counter2_in_d = bus.writeData;
          counter2_we_d = 1'b1;
        end
        AddrIrqEnable: enable_d = bus.writeData[0];
        default: ;
      endcase
    end

    if (rd_en) begin
      case (bus.address)
        AddrCounter1: begin
          read_data_d   = counter1;
          counter1_re_d = 1'b1;
        end
        AddrCounter2: begin
          read_data_d   = counter2;
          counter2_re_d = 1'b1;
        end
        // Status reads return the pending bit as it stands before this edge's update.
        AddrIrqStatus: read_data_d = {31'd0, pending_q};
        AddrIrqEnable: read_data_d = {31'd0, enable_q};
        AddrId:        read_data_d = ID_VALUE;
        default:       read_data_d = '0;
      endcase
    end

    irq_rise = irq & ~irq_prev_q;
    w1c      = wr_en && (bus.address == AddrIrqStatus) && bus.writeData[0];
    // A new rising edge outranks a clear in the same cycle.
    if (irq_rise) begin
      pending_d = 1'b1;
    end else if (w1c) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with synchronous reset; reset also cancels any in-flight strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q   <= '0;
      read_valid_q  <= 1'b0;
      counter1_in_q <= '0;
      counter2_in_q <= '0;
      counter1_we_q <= 1'b0;
      counter2_we_q <= 1'b0;
      counter1_re_q <= 1'b0;
      counter2_re_q <= 1'b0;
      pending_q     <= 1'b0;
      enable_q      <= 1'b0;
      irq_prev_q    <= 1'b0;
    end else begin
      read_data_q   <= read_data_d;
      read_valid_q  <= read_valid_d;
      counter1_in_q <= counter1_in_d;
      counter2_in_q <= counter2_in_d;
      counter1_we_q <= counter1_we_d;
      counter2_we_q <= counter2_we_d;
      counter1_re_q <= counter1_re_d;
      counter2_re_q <= counter2_re_d;
      pending_q     <= pending_d;
      enable_q      <= enable_d;
      irq_prev_q    <= irq;
    end
  end

  // Outputs come straight from flops; irqOut is the only gate after them.
  always_comb begin
    bus.readData      = read_data_q;
    bus.readDataValid = read_valid_q;
    counter1In        = counter1_in_q;
    counter2In        = counter2_in_q;
    counter1We        = counter1_we_q;
    counter2We        = counter2_we_q;
    counter1Re        = counter1_re_q;
    counter2Re        = counter2_re_q;
    irqOut            = pending_q & enable_q;
  end

endmodule

// File: tb/tb_core_bus_slave.sv
// Bench for core_bus_slave: a register-map model predicts every output each cycle, and
// directed sequences add literal expectations for the key scenarios.
module tb_core_bus_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq = 1'b0;
  logic [31:0] cnt1 = 32'h0000_0100;
  logic [31:0] cnt2 = 32'h0000_2000;

  logic        irqOut;
  logic [31:0] counter1In, counter2In;
  logic        counter1We, counter2We, counter1Re, counter2Re;

  int tests = 0;
  int fails = 0;

  core_bus_slave_if bus ();

  core_bus_slave #(.ID_VALUE(32'h0001_0001)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .irqOut     (irqOut),
    .counter1In (counter1In),
    .counter2In (counter2In),
    .counter1We (counter1We),
    .counter2We (counter2We),
    .counter1Re (counter1Re),
    .counter2Re (counter2Re),
    .counter1   (cnt1),
    .counter2   (cnt2),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Emulated free-running core counters, advancing away from the sampling edge.
  always @(negedge clk) begin
    cnt1 <= cnt1 + 32'd1;
    cnt2 <= cnt2 + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Register-map model ----------------
  logic        m_pending = 1'b0, m_enable = 1'b0, m_prev_irq = 1'b0;
  logic        e_rvalid = 1'b0, e_we1 = 1'b0, e_we2 = 1'b0, e_re1 = 1'b0, e_re2 = 1'b0;
  logic        e_irq = 1'b0;
  logic [31:0] e_rdata = '0, e_in1 = '0, e_in2 = '0;
  logic        model_ok = 1'b0;

  function automatic logic [31:0] reg_value(input logic [2:0] a);
    case (a)
      3'd0:    return cnt1;
      3'd1:    return cnt2;
      3'd2:    return {31'd0, m_pending};
      3'd3:    return {31'd0, m_enable};
      3'd4:    return 32'h0001_0001;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pending = 0; m_enable = 0; m_prev_irq = 0;
      e_rvalid = 0; e_we1 = 0; e_we2 = 0; e_re1 = 0; e_re2 = 0;
      e_rdata = 0; e_in1 = 0; e_in2 = 0;
    end else begin
      logic is_rd, rise;
      is_rd    = bus.read && !bus.write;
      e_rvalid = is_rd;
      e_re1    = is_rd && bus.address == 3'd0;
      e_re2    = is_rd && bus.address == 3'd1;
      e_rdata  = is_rd ? reg_value(bus.address) : 32'd0;
      e_we1    = bus.write && bus.address == 3'd0;
      e_we2    = bus.write && bus.address == 3'd1;
      if (e_we1) e_in1 = bus.writeData;
      if (e_we2) e_in2 = bus.writeData;
      rise       = irq && !m_prev_irq;
      m_prev_irq = irq;
      if (bus.write && bus.address == 3'd3) m_enable = bus.writeData[0];
      if (bus.write && bus.address == 3'd2 && bus.writeData[0]) m_pending = 0;
      if (rise) m_pending = 1;
    end
    e_irq    = m_pending && m_enable;
    model_ok = 1'b1;
  end

  // Compare every output against the model shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (model_ok) begin
      check("readDataValid", {31'd0, bus.readDataValid}, {31'd0, e_rvalid});
      if (e_rvalid) check("readData", bus.readData, e_rdata);
      check("counter1We", {31'd0, counter1We}, {31'd0, e_we1});
      check("counter2We", {31'd0, counter2We}, {31'd0, e_we2});
      check("counter1Re", {31'd0, counter1Re}, {31'd0, e_re1});
      check("counter2Re", {31'd0, counter2Re}, {31'd0, e_re2});
      check("counter1In", counter1In, e_in1);
      check("counter2In", counter2In, e_in2);
      check("irqOut", {31'd0, irqOut}, {31'd0, e_irq});
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic access(input logic w, input logic r, input logic [2:0] a,
                        input logic [31:0] d);
    bus.write     = w;
    bus.read      = r;
    bus.address   = a;
    bus.writeData = d;
    @(negedge clk);
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] v1, v2;

  initial begin
    bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writeData = '0;
    idle(2);
    check("rst_rvalid", {31'd0, bus.readDataValid}, 32'd0);
    check("rst_irqOut", {31'd0, irqOut}, 32'd0);
    check("rst_c1In", counter1In, 32'd0);
    reset = 1'b0;

    access(1'b0, 1'b1, 3'd4, 32'd0);
    check("id_valid", {31'd0, bus.readDataValid}, 32'd1);
    check("id_data", bus.readData, 32'h0001_0001);
    check("id_c1we", {31'd0, counter1We}, 32'd0);

    access(1'b1, 1'b0, 3'd0, 32'h0000_1000);
    check("wr0_we", {31'd0, counter1We}, 32'd1);
    check("wr0_in", counter1In, 32'h0000_1000);
    check("wr0_we2", {31'd0, counter2We}, 32'd0);
    idle(1);
    check("wr0_we_drop", {31'd0, counter1We}, 32'd0);

    access(1'b0, 1'b1, 3'd1, 32'd0);
    v1 = bus.readData;
    check("rd1a_re", {31'd0, counter2Re}, 32'd1);
    access(1'b0, 1'b1, 3'd1, 32'd0);
    v2 = bus.readData;
    check("rd1b_valid", {31'd0, bus.readDataValid}, 32'd1);
    check("rd1_delta", v2 - v1, 32'd1);
    idle(1);
    check("rd1_valid_drop", {31'd0, bus.readDataValid}, 32'd0);

    // Unmapped address: reads zero, writes produce no strobes.
    access(1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF);
    access(1'b0, 1'b1, 3'd5, 32'd0);
    check("unmapped_rd", bus.readData, 32'd0);

    // Interrupt latch, W1C and re-arm.
    access(1'b1, 1'b0, 3'd3, 32'd1);
    irq = 1'b1;
    idle(1);
    check("irq_set", {31'd0, irqOut}, 32'd1);
    idle(2);
    access(1'b1, 1'b0, 3'd2, 32'd1);
    check("irq_w1c", {31'd0, irqOut}, 32'd0);
    idle(2);
    check("irq_held_no_reset", {31'd0, irqOut}, 32'd0);
    irq = 1'b0;
    idle(1);
    irq = 1'b1;
    idle(1);
    check("irq_rearm", {31'd0, irqOut}, 32'd1);

    // Rising edge coincident with W1C keeps pending.
    irq = 1'b0;
    access(1'b1, 1'b0, 3'd2, 32'd1);
    check("irq_clr2", {31'd0, irqOut}, 32'd0);
    irq = 1'b1;
    access(1'b1, 1'b0, 3'd2, 32'd1);
    check("irq_set_beats_clr", {31'd0, irqOut}, 32'd1);
    access(1'b1, 1'b0, 3'd3, 32'd0);
    check("irq_disabled", {31'd0, irqOut}, 32'd0);
    irq = 1'b0;
    access(1'b1, 1'b0, 3'd2, 32'd1);
    irq = 1'b1;
    access(1'b1, 1'b0, 3'd2, 32'd1);
    check("irq_masked", {31'd0, irqOut}, 32'd0);
    access(1'b0, 1'b1, 3'd2, 32'd0);
    check("status_pending", bus.readData, 32'd1);
    access(1'b0, 1'b1, 3'd3, 32'd0);
    check("enable_rd", bus.readData, 32'd0);

    // Simultaneous write and read: write only.
    access(1'b1, 1'b1, 3'd0, 32'h0000_ABCD);
    check("wr_rd_we", {31'd0, counter1We}, 32'd1);
    check("wr_rd_in", counter1In, 32'h0000_ABCD);
    check("wr_rd_valid", {31'd0, bus.readDataValid}, 32'd0);
    check("wr_rd_re", {31'd0, counter1Re}, 32'd0);

    // Reset in the cycle after a read.
    access(1'b0, 1'b1, 3'd0, 32'd0);
    check("pre_rst_re", {31'd0, counter1Re}, 32'd1);
    reset = 1'b1;
    idle(1);
    check("rst_cancel_valid", {31'd0, bus.readDataValid}, 32'd0);
    check("rst_cancel_irq", {31'd0, irqOut}, 32'd0);
    reset = 1'b0;
    irq = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_bus_slave.md
# core_bus_slave

Memory-mapped register front end that drives the counter core from a host bus; it is the initiator side of the core's register interface. Decodes single-word bus reads and writes into the core's per-register write/read strobes, returns register read data with fixed one-cycle latency, and converts the core's level interrupt into a latched, maskable, write-1-to-clear interrupt toward the host. Sits between the system interconnect and one core instance.

## Interface

Parameters:
- ID_VALUE, 32'h0001_0001: constant returned by the ID register.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  3  word address of the bus access.
- write  input  1  bus write request, single cycle.
- writeData  input  32  bus write data.
- read  input  1  bus read request, single cycle.
- readData  output  32  read return data; valid only when readDataValid=1.
- readDataValid  output  1  one-cycle pulse marking readData valid.
- irqOut  output  1  host interrupt, level.
- counter1In  output  32  load value for core counter1.
- counter2In  output  32  load value for core counter2.
- counter1We  output  1  core counter1 write strobe.
- counter2We  output  1  core counter2 write strobe.
- counter1Re  output  1  core counter1 read strobe.
- counter2Re  output  1  core counter2 read strobe.
- counter1  input  32  core counter1 value.
- counter2  input  32  core counter2 value.
- irq  input  1  core level interrupt request.

## Operation

Register map (word addresses):
- 0 COUNTER1: write loads core counter1; read returns counter1.
- 1 COUNTER2: write loads core counter2; read returns counter2.
- 2 IRQ_STATUS: bit0 = pending; write 1 to bit0 clears; bits 31:1 read 0.
- 3 IRQ_ENABLE: bit0 = enable, R/W; bits 31:1 read 0, ignored on write.
- 4 ID: read returns ID_VALUE; writes ignored.
- 5-7: read 0, writes ignored, no strobes.

Rules:
- Write and read both asserted in one cycle: write performed, read ignored, no readDataValid.
- Write to 0/1: counterNIn <= writeData, counterNWe pulses 1 cycle (registered). Core loads at next edge.
- Read of 0/1: counterNRe pulses for 1 cycle coincident with readDataValid.
- Interrupt: irqPrev registers irq. Pending set when irq=1 and irqPrev=0 (rising edge). Set has priority over W1C clear in the same cycle. irq held high does not re-set pending after clear.
- irqOut = pending AND enable, registered-free combinational AND of two flops.
- All strobes are single-cycle pulses; back-to-back accesses every cycle are supported, no stalls.

Reset (reset=1 at clock edge): readData=0, readDataValid=0, counter1In=counter2In=0, all We/Re=0, pending=0, enable=0, irqPrev=0, irqOut=0. Reset mid-access cancels any pending strobe or readDataValid on the following cycle.

## Timing

- Write at cycle T -> counterNWe=1 and counterNIn valid at T+1 -> core register holds value after edge T+2.
- Read at cycle T -> readData, readDataValid=1 at T+1. Counter value sampled at edge ending T (value present during T).
- Read of IRQ_STATUS at T returns pending as of T, before any set at edge ending T.
- irq rising at T (irqPrev=0) -> pending=1 at T+1 -> irqOut=1 at T+1 if enable=1.
- W1C at T -> pending=0 at T+1 unless a rising edge also occurs at T.
- Enable write at T -> irqOut reflects new enable at T+1.

## Test plan

- Reset then read ID (addr 4) -> readDataValid at T+1, readData=32'h0001_0001; all other outputs 0.
- Write 32'h0000_1000 to addr 0 at T -> counter1We=1, counter1In=32'h0000_1000 at T+1 only; counter2We stays 0.
- Read addr 1 on consecutive cycles T, T+1 -> readDataValid high T+1 and T+2, counter2Re high same cycles, data values differ by 1 for a free-running counter.
- Enable=1, drive irq 0->1 held high -> irqOut=1 one cycle later; W1C addr 2 -> irqOut=0 and stays 0 while irq high; irq 0->1 again -> irqOut=1.
- Rising irq edge in same cycle as W1C -> pending remains 1, irqOut=1 with enable=1; with enable=0 irqOut=0, IRQ_STATUS reads 1.
- Write and read asserted together to addr 0 -> counter1We pulses, no readDataValid, no counter1Re; assert reset in cycle after a read -> readDataValid=0.
